// File: rtl/demux_pkg.sv
// Shared types and sizing constants for the demux_12 1-to-2 round-robin demultiplexer.
package demux_pkg;
  typedef enum logic {LANE0 = 1'b0, LANE1 = 1'b1} lane_e;

  localparam int DEMUX_DEF_WIDTH = 4;
  localparam int BURST_CNT_W     = 8;
  localparam int STATS_W         = 16;
endpackage

// File: rtl/demux_lane_reg.sv
// One-entry valid/ready output register for a demux lane; reports empty and
// drain status so the parent can form its combinational ready.
module demux_lane_reg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic             fill,
  input  logic [WIDTH-1:0] data_in,
  input  logic             ready_in,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out,
  output logic             empty,
  output logic             drain
);
  assign empty = ~valid_out;
  assign drain = valid_out & ready_in;

  // Fill has priority so a same-edge drain+fill keeps the lane full.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      valid_out <= 1'b0;
      data_out  <= '0;
    end else if (fill) begin
      valid_out <= 1'b1;
      data_out  <= data_in;
    end else if (drain) begin
      valid_out <= 1'b0;
    end
  end
endmodule

// File: rtl/demux_12.sv
// Registered 1-to-2 demultiplexer: round-robin bursts of BURST_LEN words per lane.
// Optional per-lane acceptance counters enabled by defining DEMUX_12_STATS_EN.
module demux_12
  import demux_pkg::*;
#(
  parameter int WIDTH     = DEMUX_DEF_WIDTH,
  parameter int BURST_LEN = 1
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid_in,
  output logic             ready_out,
  output logic [WIDTH-1:0] data_out_0,
  output logic             valid_out_0,
  input  logic             ready_in_0,
  output logic [WIDTH-1:0] data_out_1,
  output logic             valid_out_1,
  input  logic             ready_in_1
`ifdef DEMUX_12_STATS_EN
  ,
  output logic [STATS_W-1:0] count_0,
  output logic [STATS_W-1:0] count_1
`endif
);
  localparam int NUM_LANES = 2;
  localparam logic [BURST_CNT_W-1:0] LAST_CNT = BURST_CNT_W'(BURST_LEN - 1);

  lane_e                  sel, next_sel;
  logic [BURST_CNT_W-1:0] burst_cnt, next_cnt;
  logic                   accept;

  logic [NUM_LANES-1:0][WIDTH-1:0] lane_data;
  logic [NUM_LANES-1:0]            lane_vld, lane_rdy, lane_empty, lane_drain, lane_fill;

  assign lane_rdy = {ready_in_1, ready_in_0};

  // Only the selected lane gates input; a stalled idle lane never blocks.
  assign ready_out = (sel == LANE1) ? (lane_empty[1] | lane_rdy[1])
                                    : (lane_empty[0] | lane_rdy[0]);
  assign accept    = valid_in & ready_out;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    assign lane_fill[g] = accept & (sel == ((g == 1) ? LANE1 : LANE0));

    demux_lane_reg #(.WIDTH(WIDTH)) u_lane (
      .clk       (clk),
      .reset_L   (reset_L),
      .fill      (lane_fill[g]),
      .data_in   (data_in),
      .ready_in  (lane_rdy[g]),
      .data_out  (lane_data[g]),
      .valid_out (lane_vld[g]),
      .empty     (lane_empty[g]),
      .drain     (lane_drain[g])
    );
  end

  assign data_out_0  = lane_data[0];
  assign data_out_1  = lane_data[1];
  assign valid_out_0 = lane_vld[0];
  assign valid_out_1 = lane_vld[1];

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      sel       <= LANE0;
      burst_cnt <= '0;
    end else begin
      sel       <= next_sel;
      burst_cnt <= next_cnt;
    end
  end

  always_comb begin
    next_sel = sel;
    next_cnt = burst_cnt;
    if (accept) begin
      if (burst_cnt == LAST_CNT) begin
        next_sel = (sel == LANE0) ? LANE1 : LANE0;
        next_cnt = '0;
      end else begin
        next_cnt = burst_cnt + 1'b1;
      end
    end
  end

`ifdef DEMUX_12_STATS_EN
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      count_0 <= '0;
      count_1 <= '0;
    end else begin
      if (lane_fill[0]) count_0 <= count_0 + 1'b1;
      if (lane_fill[1]) count_1 <= count_1 + 1'b1;
    end
  end
`endif

  // Drain status is informational for the parent; the lanes act on it locally.
  logic unused_drain;
  assign unused_drain = ^lane_drain;
endmodule

// File: tb/tb_demux_12.sv
// Scoreboard bench for demux_12: two instances (BURST_LEN 1 and 3) driven with
// random traffic; a word-index model decides each word's lane.
module tb_demux_12;
  logic clk = 1'b0;
  logic reset_L;
  always #5 clk = ~clk;

  logic [3:0] data_in  [2];
  logic [3:0] data_o0  [2];
  logic [3:0] data_o1  [2];
  logic [1:0] valid_in, ready_out, vo0, vo1, ri0, ri1;
`ifdef DEMUX_12_STATS_EN
  logic [15:0] cnt0 [2];
  logic [15:0] cnt1 [2];
`endif

  demux_12 #(.WIDTH(4), .BURST_LEN(1)) dut_a (
    .clk(clk), .reset_L(reset_L), .data_in(data_in[0]), .valid_in(valid_in[0]),
    .ready_out(ready_out[0]), .data_out_0(data_o0[0]), .valid_out_0(vo0[0]),
    .ready_in_0(ri0[0]), .data_out_1(data_o1[0]), .valid_out_1(vo1[0]),
    .ready_in_1(ri1[0])
`ifdef DEMUX_12_STATS_EN
    , .count_0(cnt0[0]), .count_1(cnt1[0])
`endif
  );

  demux_12 #(.WIDTH(4), .BURST_LEN(3)) dut_b (
    .clk(clk), .reset_L(reset_L), .data_in(data_in[1]), .valid_in(valid_in[1]),
    .ready_out(ready_out[1]), .data_out_0(data_o0[1]), .valid_out_0(vo0[1]),
    .ready_in_0(ri0[1]), .data_out_1(data_o1[1]), .valid_out_1(vo1[1]),
    .ready_in_1(ri1[1])
`ifdef DEMUX_12_STATS_EN
    , .count_0(cnt0[1]), .count_1(cnt1[1])
`endif
  );

  int errors = 0;
  int checks = 0;

  // Expected contents of each lane register, index d*2+lane.
  logic [3:0]  q [4][$];
  int          n_acc [2];
  logic [15:0] exp_cnt [2][2];
  logic        pend [2];
  logic [3:0]  pend_data [2];
  logic [3:0]  seq;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int burst_len(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  // Word number n (from reset) belongs to lane (n / BURST_LEN) mod 2.
  function automatic int lane_of(input int d, input int n);
    return (n / burst_len(d)) % 2;
  endfunction

  // Monitor: compare each lane register against its queue head; pop on handshake.
  always @(negedge clk) begin
    if (reset_L) begin
      for (int d = 0; d < 2; d++) begin
        for (int l = 0; l < 2; l++) begin
          logic       v, r;
          logic [3:0] dat;
          int         idx;
          idx = d * 2 + l;
          v   = (l == 0) ? vo0[d] : vo1[d];
          r   = (l == 0) ? ri0[d] : ri1[d];
          dat = (l == 0) ? data_o0[d] : data_o1[d];
          chk($sformatf("valid d%0d l%0d", d, l), 32'(v), 32'(q[idx].size() != 0));
          if (q[idx].size() != 0) begin
            chk($sformatf("data d%0d l%0d", d, l), 32'(dat), 32'(q[idx][0]));
            if (r) void'(q[idx].pop_front());
          end
        end
`ifdef DEMUX_12_STATS_EN
        chk($sformatf("count_0 d%0d", d), 32'(cnt0[d]), 32'(exp_cnt[d][0]));
        chk($sformatf("count_1 d%0d", d), 32'(cnt1[d]), 32'(exp_cnt[d][1]));
`endif
      end
    end
  end

  // mode 0: all ready, sequential data; 1: random light backpressure; 2: heavy.
  task automatic cycle(input int mode);
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (pend[d]) begin
        int l;
        l = lane_of(d, n_acc[d]);
        q[d * 2 + l].push_back(pend_data[d]);
        exp_cnt[d][l] = exp_cnt[d][l] + 16'd1;
        n_acc[d]++;
      end
    end
    #1;
    for (int d = 0; d < 2; d++) begin
      case (mode)
        0: begin ri0[d] = 1'b1; ri1[d] = 1'b1; valid_in[d] = 1'b1; data_in[d] = seq; end
        1: begin
          ri0[d] = ($urandom_range(0, 3) != 0); ri1[d] = ($urandom_range(0, 3) != 0);
          valid_in[d] = ($urandom_range(0, 3) != 0); data_in[d] = 4'($urandom);
        end
        3: begin ri0[d] = 1'b1; ri1[d] = 1'b1; valid_in[d] = 1'b0; data_in[d] = 4'($urandom); end
        default: begin
          ri0[d] = ($urandom_range(0, 9) < 3); ri1[d] = ($urandom_range(0, 9) < 3);
          valid_in[d] = ($urandom_range(0, 1) != 0); data_in[d] = 4'($urandom);
        end
      endcase
    end
    seq = seq + 4'd1;
    #1;
    for (int d = 0; d < 2; d++) begin
      int  l;
      logic exp_rdy;
      l = lane_of(d, n_acc[d]);
      exp_rdy = (q[d * 2 + l].size() == 0) || ((l == 0) ? ri0[d] : ri1[d]);
      chk($sformatf("ready_out d%0d", d), 32'(ready_out[d]), 32'(exp_rdy));
      pend[d]      = valid_in[d] && exp_rdy;
      pend_data[d] = data_in[d];
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4; i++) q[i].delete();
    for (int d = 0; d < 2; d++) begin
      n_acc[d] = 0; pend[d] = 1'b0;
      exp_cnt[d][0] = '0; exp_cnt[d][1] = '0;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s valid_out_0 d%0d", tag, d), 32'(vo0[d]), 32'd0);
      chk($sformatf("%s valid_out_1 d%0d", tag, d), 32'(vo1[d]), 32'd0);
      chk($sformatf("%s data_out_0 d%0d", tag, d), 32'(data_o0[d]), 32'd0);
      chk($sformatf("%s data_out_1 d%0d", tag, d), 32'(data_o1[d]), 32'd0);
`ifdef DEMUX_12_STATS_EN
      chk($sformatf("%s count_0 d%0d", tag, d), 32'(cnt0[d]), 32'd0);
      chk($sformatf("%s count_1 d%0d", tag, d), 32'(cnt1[d]), 32'd0);
`endif
    end
  endtask

  initial begin
    seq = '0;
    model_clear();
    reset_L = 1'b0;
    for (int d = 0; d < 2; d++) begin
      valid_in[d] = 1'b1; data_in[d] = 4'hA; ri0[d] = 1'b1; ri1[d] = 1'b1;
    end
    repeat (3) @(posedge clk);
    #2 check_reset_outputs("reset");
    @(negedge clk);
    valid_in = '0;
    reset_L  = 1'b1;

    // 16 back-to-back words 0..15, all lanes ready.
    repeat (16) cycle(0);
    repeat (300) cycle(1);

    // Asynchronous reset between clock edges, mid-stream.
    @(posedge clk);
    #3 reset_L = 1'b0;
    #1 check_reset_outputs("async reset");
    model_clear();
    valid_in = '0;
    @(negedge clk);
    reset_L = 1'b1;

    repeat (300) cycle(2);
    repeat (200) cycle(1);
    repeat (6) cycle(3);
    @(negedge clk);
    #1;
    for (int i = 0; i < 4; i++) chk($sformatf("drained q%0d", i), 32'(q[i].size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
